// File: rtl/jk_seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : jk_seq_pkg
// Brief  : Mode encoding and Gray/binary helpers shared by the JK sequencer.
// Rev    : 1.0
// ============================================================================
package jk_seq_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_GRAY = 2'b10,
        MODE_DOWN = 2'b11
    } mode_e;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_seq_gen_if.sv
`default_nettype none
// ============================================================================
// Module : jk_seq_gen_if
// Brief  : Control, load handshake and observation bus of the JK sequencer.
// Rev    : 1.0
// ============================================================================
interface jk_seq_gen_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic             load_valid;
    logic [WIDTH-1:0] load_val;
    logic             load_ready;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             wrap;

    modport master (
        output en, mode, load_valid, load_val,
        input  load_ready, q, j_vec, k_vec, wrap
    );

    modport slave (
        input  en, mode, load_valid, load_val,
        output load_ready, q, j_vec, k_vec, wrap
    );
endinterface
`default_nettype wire

// File: rtl/jk_seq_gen_cell.sv
`default_nettype none
// ============================================================================
// Module : jk_cell
// Brief  : Single JK flip-flop with asynchronous active-low clear.
// Rev    : 1.0
// ============================================================================
module jk_cell (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic j_i,
    input  wire logic k_i,
    output logic      q_o
);
    logic q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            case ({j_i, k_i})
                2'b10:   q_q <= 1'b1;
                2'b01:   q_q <= 1'b0;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o = q_q;
endmodule
`default_nettype wire

// File: rtl/jk_seq_gen.sv
`default_nettype none
// ============================================================================
// Module : jk_seq_gen
// Brief  : Up/down/Gray sequence generator built from JK cells with a
//          one-cycle-backoff load handshake. Gray mode requires the macro
//          JK_SEQ_GEN_GRAY_EN; without it mode 10 holds.
// Rev    : 1.0
// ============================================================================
module jk_seq_gen #(
    parameter int WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    jk_seq_gen_if.slave   bus
);
    import jk_seq_pkg::*;

    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             accept;
    logic             wrap_d;
    logic             wrap_q;
    logic             load_ready_d;
    logic             load_ready_q;

`ifdef JK_SEQ_GEN_GRAY_EN
    localparam logic [WIDTH-1:0] C_GRAY_MAX = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] gray_bin;
    logic [WIDTH-1:0] gray_next;

    assign gray_bin  = WIDTH'(gray2bin(MAX_WIDTH'(q))) + C_ONE;
    assign gray_next = WIDTH'(bin2gray(MAX_WIDTH'(gray_bin)));
`endif

    always_comb begin
        accept       = bus.load_valid && load_ready_q;
        load_ready_d = !accept;
        d            = q;
        wrap_d       = 1'b0;
        // A load wins over counting and never signals a wrap.
        if (accept) begin
            d = bus.load_val;
        end else if (bus.en) begin
            case (mode_e'(bus.mode))
                MODE_UP: begin
                    d      = q + C_ONE;
                    wrap_d = (q == C_ALL_ONES);
                end
                MODE_DOWN: begin
                    d      = q - C_ONE;
                    wrap_d = (q == '0);
                end
                MODE_GRAY: begin
`ifdef JK_SEQ_GEN_GRAY_EN
                    d      = gray_next;
                    wrap_d = (q == C_GRAY_MAX);
`else
                    d      = q;
`endif
                end
                default: d = q;
            endcase
        end
    end

    // Minimised excitation: set only from 0, clear only from 1, never toggle.
    assign j = ~q & d;
    assign k = q & ~d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j_i   (j[i]),
            .k_i   (k[i]),
            .q_o   (q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ready_q <= 1'b1;
            wrap_q       <= 1'b0;
        end else begin
            load_ready_q <= load_ready_d;
            wrap_q       <= wrap_d;
        end
    end

    assign bus.q          = q;
    assign bus.j_vec      = j;
    assign bus.k_vec      = k;
    assign bus.wrap       = wrap_q;
    assign bus.load_ready = load_ready_q;
endmodule
`default_nettype wire

// File: doc/jk_seq_gen.md
JK_SEQ_GEN -- requirements
Module: jk_seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of JK state bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  advance state per mode when high.
REQ-005 SHALL have port mode  input  2  00 hold, 01 up, 10 gray-up, 11 down.
REQ-006 SHALL have port load_valid  input  1  load request.
REQ-007 SHALL have port load_val  input  WIDTH  value to load.
REQ-008 SHALL have port load_ready  output  1  load can be accepted this cycle.
REQ-009 SHALL have port q  output  WIDTH  current state, straight from JK cells.
REQ-010 SHALL have port j_vec  output  WIDTH  J drive applied this cycle.
REQ-011 SHALL have port k_vec  output  WIDTH  K drive applied this cycle.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse on sequence wrap.

Function
REQ-013 SHALL derive per-bit desired next state d from priority: accepted load (load_val) > en with mode > hold (d=q).
REQ-014 SHALL convert d to J/K using minimized excitation: q=0 -> J=d, K=0; q=1 -> J=0, K=~d.
REQ-015 SHALL never drive J=K=1; toggles SHALL come only via the above rules.
REQ-016 SHALL update q one clock after the cycle d is computed (latency 1); j_vec/k_vec SHALL be combinational from q and inputs.
REQ-017 Up mode SHALL compute d=q+1 modulo 2^WIDTH; down mode d=q-1 modulo 2^WIDTH.
REQ-018 Gray mode SHALL treat q as Gray code: d=bin2gray(gray2bin(q)+1) modulo 2^WIDTH.
REQ-019 Load SHALL be accepted iff load_valid && load_ready at a rising edge.
REQ-020 load_ready SHALL drop for exactly the cycle after an accepted load, then reassert; load_valid held high thus loads every second cycle.
REQ-021 During the load_ready-low cycle, en/mode SHALL still operate normally.
REQ-022 wrap SHALL pulse the cycle after q moves all-ones->0 (up), 0->all-ones (down), or Gray-max (1 followed by WIDTH-1 zeros)->0 (gray); loads SHALL never raise wrap.
REQ-023 en=1 with mode=00 SHALL hold and SHALL not raise wrap.
REQ-024 load_val ignored when not accepted; X on load_val SHALL not propagate while load_valid=0.

Reset
REQ-025 rst_n low SHALL immediately force q=0, wrap=0, load_ready=1, independent of clk.
REQ-026 Reset mid-load or mid-count SHALL discard the pending operation; first edge after release SHALL act on current inputs.

Configuration
REQ-027 Macro JK_SEQ_GEN_GRAY_EN defined: mode 10 SHALL behave per REQ-018.
REQ-028 Macro JK_SEQ_GEN_GRAY_EN undefined: mode 10 SHALL hold (as 00), no Gray converters SHALL be synthesized, wrap never asserted for mode 10.

Structure
REQ-029 Shared package jk_seq_pkg SHALL hold mode enum (MODE_HOLD, MODE_UP, MODE_GRAY, MODE_DOWN) and bin2gray/gray2bin functions.
REQ-030 Each state bit SHALL be an instance of sub-module jk_cell (J, K, clk, rst_n, Q; JK characteristic with async active-low clear); excitation, load handshake and wrap logic SHALL live in jk_seq_gen.

Verification (WIDTH=4)
REQ-031 Reset then en=1, mode=01 for 17 cycles -> q 0..15,0,1; wrap high only in cycle after 15->0; J=K=1 never seen.
REQ-032 mode=11 from q=0 -> q=15,14,...; wrap pulses after 0->15; at q=5->4 j_vec=0000, k_vec=0001.
REQ-033 GRAY_EN defined, mode=10, 16 cycles -> q 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0; wrap after 8->0; GRAY_EN undefined -> q stays 0.
REQ-034 load_valid held high, load_val=9, en=1 mode=01 -> load_ready 1,0,1,0; q 9,10,9,10; no wrap.
REQ-035 rst_n pulsed low mid-cycle at q=7 with load pending -> q=0, load_ready=1 immediately, no clk edge required.
REQ-036 load at q=15 with load_val=0 in up mode -> q=0, wrap stays 0.
